// File: rtl/bayer_mosaic_if.sv
// rtl/bayer_mosaic_if.sv - pixel-in / Bayer-out bus for bayer_mosaic
// The slave side is the mosaic block; the master side is the upstream source and downstream sink.
interface bayer_mosaic_if;
  logic [7:0]  i_r;
  logic [7:0]  i_g;
  logic [7:0]  i_b;
  logic        i_valid;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_done;
  logic [31:0] o_x_cnt;
  logic [31:0] o_y_cnt;
  logic [31:0] o_mosaic_cnt;

  modport master (
    output i_r, i_g, i_b, i_valid,
    input  o_data, o_valid, o_done, o_x_cnt, o_y_cnt, o_mosaic_cnt
  );

  modport slave (
    input  i_r, i_g, i_b, i_valid,
    output o_data, o_valid, o_done, o_x_cnt, o_y_cnt, o_mosaic_cnt
  );
endinterface

// File: rtl/bayer_mosaic.sv
// rtl/bayer_mosaic.sv - RGB raster to 8-bit Bayer mosaic with per-frame latched digital gain
// Two-stage free-running pipeline: CFA select, then Q2.6 gain multiply with saturation.
module bayer_mosaic #(
  parameter int         WIDTH       = 1920,
  parameter int         HEIGHT      = 1080,
  parameter logic [1:0] BAYER_PHASE = 2'd0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_gain_r,
  input  logic [7:0]    i_gain_g,
  input  logic [7:0]    i_gain_b,
  bayer_mosaic_if.slave io_pix
);

  localparam logic [31:0] X_LAST     = 32'(WIDTH - 1);
  localparam logic [31:0] Y_LAST     = 32'(HEIGHT - 1);
  localparam logic [31:0] CNT_LAST   = 32'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]  GAIN_UNITY = 8'd64;

  // input-side raster position of the next accepted pixel
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_cnt;

  logic [7:0]  r_gain_r;
  logic [7:0]  r_gain_g;
  logic [7:0]  r_gain_b;

  logic        w_frame_start;
  logic        w_frame_last;
  logic [7:0]  w_gain_r;
  logic [7:0]  w_gain_g;
  logic [7:0]  w_gain_b;
  logic [1:0]  w_site;
  logic [7:0]  w_comp;
  logic [7:0]  w_gain;

  logic        r_s1_valid;
  logic [7:0]  r_s1_comp;
  logic [7:0]  r_s1_gain;
  logic [31:0] r_s1_x;
  logic [31:0] r_s1_y;
  logic [31:0] r_s1_cnt;
  logic        r_s1_last;

  logic [15:0] w_prod;
  logic [15:0] w_scaled;
  logic [7:0]  w_data;

  logic        r_s2_valid;
  logic [7:0]  r_s2_data;
  logic [31:0] r_s2_x;
  logic [31:0] r_s2_y;
  logic [31:0] r_s2_cnt;
  logic        r_s2_last;

  assign w_frame_start = (r_x == '0) && (r_y == '0);
  assign w_frame_last  = (r_cnt == CNT_LAST);

  // pixel (0,0) uses the gains it captures, not the previous frame's
  assign w_gain_r = w_frame_start ? i_gain_r : r_gain_r;
  assign w_gain_g = w_frame_start ? i_gain_g : r_gain_g;
  assign w_gain_b = w_frame_start ? i_gain_b : r_gain_b;

  assign w_site = {r_y[0], r_x[0]} ^ BAYER_PHASE;

  always_comb begin
    w_comp = io_pix.i_g;
    w_gain = w_gain_g;
    case (w_site)
      2'b01: begin
        w_comp = io_pix.i_b;
        w_gain = w_gain_b;
      end
      2'b10: begin
        w_comp = io_pix.i_r;
        w_gain = w_gain_r;
      end
      default: begin
        w_comp = io_pix.i_g;
        w_gain = w_gain_g;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_gain_r <= GAIN_UNITY;
      r_gain_g <= GAIN_UNITY;
      r_gain_b <= GAIN_UNITY;
    end else if (io_pix.i_valid) begin
      if (w_frame_start) begin
        r_gain_r <= i_gain_r;
        r_gain_g <= i_gain_g;
        r_gain_b <= i_gain_b;
      end
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 32'd1;
      end else begin
        r_x <= r_x + 32'd1;
      end
      r_cnt <= w_frame_last ? '0 : r_cnt + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_comp  <= '0;
      r_s1_gain  <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_cnt   <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= io_pix.i_valid;
      if (io_pix.i_valid) begin
        r_s1_comp <= w_comp;
        r_s1_gain <= w_gain;
        r_s1_x    <= r_x;
        r_s1_y    <= r_y;
        r_s1_cnt  <= r_cnt;
        r_s1_last <= w_frame_last;
      end
    end
  end

  // Q2.6 gain: drop six fraction bits, clamp anything above 255
  assign w_prod   = {8'd0, r_s1_comp} * {8'd0, r_s1_gain};
  assign w_scaled = w_prod >> 6;
  assign w_data   = (|w_scaled[15:8]) ? 8'hFF : w_scaled[7:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_x     <= '0;
      r_s2_y     <= '0;
      r_s2_cnt   <= '0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_data;
        r_s2_x    <= r_s1_x;
        r_s2_y    <= r_s1_y;
        r_s2_cnt  <= r_s1_cnt;
        r_s2_last <= r_s1_last;
      end
    end
  end

  assign io_pix.o_data       = r_s2_data;
  assign io_pix.o_valid      = r_s2_valid;
  assign io_pix.o_done       = r_s2_valid & r_s2_last;
  assign io_pix.o_x_cnt      = r_s2_x;
  assign io_pix.o_y_cnt      = r_s2_y;
  assign io_pix.o_mosaic_cnt = r_s2_cnt;

endmodule

// File: tb/tb_bayer_mosaic.sv
// tb/tb_bayer_mosaic.sv - directed bench for bayer_mosaic on a 4x2 frame
// Two instances share stimulus: CFA phase 0 and phase 3.
module tb_bayer_mosaic;

  logic       tb_clk = 1'b0;
  logic       tb_reset;
  logic [7:0] tb_r, tb_g, tb_b;
  logic       tb_valid;
  logic [7:0] tb_gain_r, tb_gain_g, tb_gain_b;

  int errors = 0;
  int checks = 0;
  int m_base = 0;

  logic [7:0] e0 [16];
  logic [7:0] e3 [16];

  always #5 tb_clk = ~tb_clk;

  bayer_mosaic_if if0 ();
  bayer_mosaic_if if3 ();

  assign if0.i_r = tb_r;
  assign if0.i_g = tb_g;
  assign if0.i_b = tb_b;
  assign if0.i_valid = tb_valid;
  assign if3.i_r = tb_r;
  assign if3.i_g = tb_g;
  assign if3.i_b = tb_b;
  assign if3.i_valid = tb_valid;

  bayer_mosaic #(.WIDTH(4), .HEIGHT(2), .BAYER_PHASE(2'd0)) dut0 (
    .i_clk(tb_clk), .i_reset(tb_reset),
    .i_gain_r(tb_gain_r), .i_gain_g(tb_gain_g), .i_gain_b(tb_gain_b),
    .io_pix(if0)
  );

  bayer_mosaic #(.WIDTH(4), .HEIGHT(2), .BAYER_PHASE(2'd3)) dut3 (
    .i_clk(tb_clk), .i_reset(tb_reset),
    .i_gain_r(tb_gain_r), .i_gain_g(tb_gain_g), .i_gain_b(tb_gain_b),
    .io_pix(if3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // n back-to-back beats plus one idle beat; output of beat k-1 is visible after tick k
  task automatic stream(input string tag, input int n, input int chg_at, input logic [7:0] chg_g);
    int c;
    for (int k = 0; k <= n; k++) begin
      if (k == chg_at) tb_gain_g = chg_g;
      tb_valid = (k < n);
      tick();
      if (k >= 1) begin
        c = (m_base + k - 1) % 8;
        chk({tag, "_valid"}, 32'(if0.o_valid), 32'd1);
        chk({tag, "_data0"}, 32'(if0.o_data), 32'(e0[k-1]));
        chk({tag, "_data3"}, 32'(if3.o_data), 32'(e3[k-1]));
        chk({tag, "_x"}, if0.o_x_cnt, 32'(c % 4));
        chk({tag, "_y"}, if0.o_y_cnt, 32'(c / 4));
        chk({tag, "_cnt"}, if0.o_mosaic_cnt, 32'(c));
        chk({tag, "_done"}, 32'(if0.o_done), 32'(c == 7));
      end
    end
    m_base += n;
  endtask

  logic       t3_vin [7];
  logic       t3_ev  [7];
  logic [7:0] t3_data [7];
  int         t3_cnt [7];

  initial begin
    tb_reset = 1'b1;
    tb_valid = 1'b0;
    tb_r = 8'd10;
    tb_g = 8'd20;
    tb_b = 8'd30;
    tb_gain_r = 8'd64;
    tb_gain_g = 8'd64;
    tb_gain_b = 8'd64;
    tick();
    tick();
    chk("rst_valid", 32'(if0.o_valid), 32'd0);
    chk("rst_done", 32'(if0.o_done), 32'd0);
    chk("rst_data", 32'(if0.o_data), 32'd0);
    chk("rst_x", if0.o_x_cnt, 32'd0);
    chk("rst_y", if0.o_y_cnt, 32'd0);
    chk("rst_cnt", if0.o_mosaic_cnt, 32'd0);
    tb_reset = 1'b0;

    // unity gain, both CFA phases
    e0 = '{8'd20, 8'd30, 8'd20, 8'd30, 8'd10, 8'd20, 8'd10, 8'd20, 0, 0, 0, 0, 0, 0, 0, 0};
    e3 = '{8'd20, 8'd10, 8'd20, 8'd10, 8'd30, 8'd20, 8'd30, 8'd20, 0, 0, 0, 0, 0, 0, 0, 0};
    stream("t1", 8, -1, 8'd64);

    // red gain 2.0 saturates 200 -> 255
    tb_gain_r = 8'd128;
    tb_r = 8'd200;
    e0 = '{8'd20, 8'd30, 8'd20, 8'd30, 8'd255, 8'd20, 8'd255, 8'd20, 0, 0, 0, 0, 0, 0, 0, 0};
    e3 = '{8'd20, 8'd255, 8'd20, 8'd255, 8'd30, 8'd20, 8'd30, 8'd20, 0, 0, 0, 0, 0, 0, 0, 0};
    stream("t2a", 8, -1, 8'd64);

    // red gain 1.5: 100 -> 150
    tb_gain_r = 8'd96;
    tb_r = 8'd100;
    e0 = '{8'd20, 8'd30, 8'd20, 8'd30, 8'd150, 8'd20, 8'd150, 8'd20, 0, 0, 0, 0, 0, 0, 0, 0};
    e3 = '{8'd20, 8'd150, 8'd20, 8'd150, 8'd30, 8'd20, 8'd30, 8'd20, 0, 0, 0, 0, 0, 0, 0, 0};
    stream("t2b", 8, -1, 8'd64);

    // gainG drops to 0.5 at pixel 3: takes effect only in the following frame
    tb_gain_r = 8'd64;
    tb_r = 8'd10;
    e0 = '{8'd20, 8'd30, 8'd20, 8'd30, 8'd10, 8'd20, 8'd10, 8'd20,
           8'd10, 8'd30, 8'd10, 8'd30, 8'd10, 8'd10, 8'd10, 8'd10};
    e3 = '{8'd20, 8'd10, 8'd20, 8'd10, 8'd30, 8'd20, 8'd30, 8'd20,
           8'd10, 8'd10, 8'd10, 8'd10, 8'd30, 8'd10, 8'd30, 8'd10};
    stream("t4", 16, 3, 8'd32);

    // bubbles: valid 1,0,0,1,1 then idle
    tb_gain_g = 8'd64;
    t3_vin  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    t3_ev   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t3_data = '{8'd0, 8'd20, 8'd20, 8'd20, 8'd30, 8'd20, 8'd20};
    t3_cnt  = '{0, 0, 0, 0, 1, 2, 2};
    for (int k = 0; k < 7; k++) begin
      tb_valid = t3_vin[k];
      tick();
      chk("t3_valid", 32'(if0.o_valid), 32'(t3_ev[k]));
      if (k >= 1) begin
        chk("t3_data", 32'(if0.o_data), 32'(t3_data[k]));
        chk("t3_cnt", if0.o_mosaic_cnt, 32'(t3_cnt[k]));
        chk("t3_x", if0.o_x_cnt, 32'(t3_cnt[k]));
        chk("t3_y", if0.o_y_cnt, 32'd0);
      end
    end

    // mid-frame reset at pixel 5 discards in-flight pixels and restarts at (0,0)
    tb_valid = 1'b1;
    tick();
    tb_gain_g = 8'd32;
    tick();
    chk("t5_pre_valid", 32'(if0.o_valid), 32'd1);
    chk("t5_pre_data", 32'(if0.o_data), 32'd30);
    chk("t5_pre_cnt", if0.o_mosaic_cnt, 32'd3);
    tb_reset = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(if0.o_valid), 32'd0);
    chk("t5_rst_done", 32'(if0.o_done), 32'd0);
    chk("t5_rst_data", 32'(if0.o_data), 32'd0);
    tb_reset = 1'b0;
    tick();
    chk("t5_gap_valid", 32'(if0.o_valid), 32'd0);
    tb_valid = 1'b0;
    tick();
    chk("t5_post_valid", 32'(if0.o_valid), 32'd1);
    chk("t5_post_x", if0.o_x_cnt, 32'd0);
    chk("t5_post_y", if0.o_y_cnt, 32'd0);
    chk("t5_post_cnt", if0.o_mosaic_cnt, 32'd0);
    chk("t5_post_data", 32'(if0.o_data), 32'd10);
    chk("t5_post_done", 32'(if0.o_done), 32'd0);
    tick();
    chk("t5_tail_valid", 32'(if0.o_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
